mdio_master: RTL and testbench

- Clause-22 MDIO management master. Converts a one-cycle start request into a complete MDC/MDIO read or write frame to an external PHY.
- Sits between the system control logic and the top-level MDIO tri-state pad.
- The pad is built outside this block from mdio_o/mdio_en, and the pad input is returned on mdio_in.

---
 rtl/mdio_master_if.sv | 23 ++
 rtl/mdio_master.sv | 152 +++++++++++++++
 tb/tb_mdio_master.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mdio_master_if.sv
// Request/response and MDIO pad signals between system control logic and mdio_master.
interface mdio_master_if;
   logic        start_flag;
   logic        r_w;
   logic [4:0]  phy_add;
   logic [4:0]  reg_add;
   logic [15:0] write_reg_data;
   logic        mdio_in;
   logic [15:0] read_reg_data;
   logic        mdio_en;
   logic        mdio_o;
   logic        mdc;

   modport master (
      input  start_flag, r_w, phy_add, reg_add, write_reg_data, mdio_in,
      output read_reg_data, mdio_en, mdio_o, mdc
   );

   modport slave (
      output start_flag, r_w, phy_add, reg_add, write_reg_data, mdio_in,
      input  read_reg_data, mdio_en, mdio_o, mdc
   );
endinterface

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: one start pulse produces a full MDC/MDIO read or write frame.
// Optional MDIO_PREAMBLE_SUPPRESS_EN drops the 32-bit preamble (32-period frames).
module mdio_master #(
   parameter int unsigned MDC_HALF = 10
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   mdio_master_if.master bus
);
   typedef enum logic [3:0] {
      S_IDLE, S_WAIT, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
   } state_t;

   localparam int unsigned CW = $clog2(MDC_HALF);

   state_t      state, nxt_state;
   logic [CW-1:0] div_cnt;
   logic        mdc_q, tick, fall, rise;
   logic [4:0]  bit_cnt, nxt_cnt, last;
   logic        rw_q;
   logic [4:0]  phy_q, reg_q;
   logic [15:0] data_q, shift_q, rd_q, nxt_rd;
   logic        mdo_q, en_q, nxt_o, nxt_en, cap;

   assign tick = (div_cnt == CW'(MDC_HALF - 1));
   assign fall = tick &  mdc_q;
   assign rise = tick & ~mdc_q;

   always_comb begin
      nxt_state = state;
      nxt_cnt   = bit_cnt;
      nxt_o     = mdo_q;
      nxt_en    = en_q;
      nxt_rd    = rd_q;
      cap       = 1'b0;
      last      = 5'd1;

      case (state)
         S_PRE:            last = 5'd31;
         S_PHYAD, S_REGAD: last = 5'd4;
         S_DATA:           last = 5'd15;
         default:          last = 5'd1;
      endcase

      // Position (field, bit) advances on a fall; the bit for the new position is driven at once.
      case (state)
         S_IDLE: begin
            if (bus.start_flag) begin
               cap       = 1'b1;
               nxt_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (fall) begin
               nxt_cnt = '0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
               nxt_state = S_ST;
`else
               nxt_state = S_PRE;
`endif
            end
         end
         default: begin
            if (fall) begin
               if (bit_cnt == last) begin
                  nxt_cnt = '0;
                  case (state)
                     S_PRE:   nxt_state = S_ST;
                     S_ST:    nxt_state = S_OP;
                     S_OP:    nxt_state = S_PHYAD;
                     S_PHYAD: nxt_state = S_REGAD;
                     S_REGAD: nxt_state = S_TA;
                     S_TA:    nxt_state = S_DATA;
                     default: begin
                        nxt_state = S_IDLE;
                        if (rw_q) nxt_rd = shift_q;
                     end
                  endcase
               end else begin
                  nxt_cnt = bit_cnt + 5'd1;
               end
            end
         end
      endcase

      if (fall && state != S_IDLE) begin
         nxt_o  = 1'b1;
         nxt_en = 1'b1;
         case (nxt_state)
            S_PRE:   nxt_o = 1'b1;
            S_ST:    nxt_o = nxt_cnt[0];
            S_OP:    nxt_o = nxt_cnt[0] ^ rw_q;
            S_PHYAD: nxt_o = phy_q[3'd4 - nxt_cnt[2:0]];
            S_REGAD: nxt_o = reg_q[3'd4 - nxt_cnt[2:0]];
            S_TA: begin
               nxt_en = ~rw_q;
               nxt_o  = rw_q | ~nxt_cnt[0];
            end
            S_DATA: begin
               nxt_en = ~rw_q;
               nxt_o  = rw_q | data_q[~nxt_cnt[3:0]];
            end
            default: begin
               nxt_o  = 1'b1;
               nxt_en = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         div_cnt <= '0;
         mdc_q   <= 1'b0;
         state   <= S_IDLE;
         bit_cnt <= '0;
         mdo_q   <= 1'b1;
         en_q    <= 1'b0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         phy_q   <= '0;
         reg_q   <= '0;
         data_q  <= '0;
         shift_q <= '0;
      end else begin
         if (tick) begin
            div_cnt <= '0;
            mdc_q   <= ~mdc_q;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
         state   <= nxt_state;
         bit_cnt <= nxt_cnt;
         mdo_q   <= nxt_o;
         en_q    <= nxt_en;
         rd_q    <= nxt_rd;
         if (cap) begin
            rw_q   <= bus.r_w;
            phy_q  <= bus.phy_add;
            reg_q  <= bus.reg_add;
            data_q <= bus.write_reg_data;
         end
         if (rise && state == S_DATA && rw_q)
            shift_q <= {shift_q[14:0], bus.mdio_in};
      end
   end

   assign bus.mdc           = mdc_q;
   assign bus.mdio_o        = mdo_q;
   assign bus.mdio_en       = en_q;
   assign bus.read_reg_data = rd_q;
endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: table plus random frames against a frame-level model.
`timescale 1ns/1ps
module tb_mdio_master;
   localparam int unsigned HALF = 4;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   localparam int FL = 32;
`else
   localparam int FL = 64;
`endif
   localparam int LIM = 8 * HALF + 8;
   localparam logic [63:0] FMASK = (FL == 64) ? {64{1'b1}} : {32'h0, 32'hFFFF_FFFF};

   typedef struct {
      bit        rw;
      bit [4:0]  phy;
      bit [4:0]  rg;
      bit [15:0] wd;
      bit [15:0] rin;
      int        mid;
   } vec_t;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   mdio_master_if bus();

   mdio_master #(.MDC_HALF(HALF)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad = 0;
   bit stuck = 1'b0;
   logic [15:0] last_rd = '0;
   vec_t vecs[11];

   task automatic check(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
      end
   endtask

   task automatic wait_level(input logic v);
      if (stuck) return;
      for (int k = 0; k < LIM && bus.mdc !== v; k++) @(negedge sys_clk);
      if (bus.mdc !== v) begin
         stuck = 1'b1;
         check("mdc_timeout", 0, {63'b0, bus.mdc}, {63'b0, v});
      end
   endtask

   task automatic drive_req(input bit rw, input bit [4:0] phy, input bit [4:0] rg, input bit [15:0] wd);
      @(negedge sys_clk);
      bus.r_w            = rw;
      bus.phy_add        = phy;
      bus.reg_add        = rg;
      bus.write_reg_data = wd;
      bus.start_flag     = 1'b1;
      @(negedge sys_clk);
      bus.start_flag     = 1'b0;
   endtask

   task automatic wait_frame_start(input int idx);
      int k;
      k = 0;
      while (bus.mdio_en !== 1'b1 && k < 2 * LIM) begin
         @(negedge sys_clk);
         k++;
      end
      check("start", idx, {63'b0, bus.mdio_en}, 64'd1);
   endtask

   task automatic run_frame(input vec_t v, input int idx);
      logic [63:0] go, ge, eo, ee;
      int k;
      drive_req(v.rw, v.phy, v.rg, v.wd);
      wait_frame_start(idx);
      if (bus.mdio_en !== 1'b1) return;
      go = '0;
      ge = '0;
      for (int i = 0; i < FL; i++) begin
         wait_level(1'b0);
         wait_level(1'b1);
         go = {go[62:0], bus.mdio_o};
         ge = {ge[62:0], bus.mdio_en};
         if (v.rw && i + 1 >= FL - 16 && i + 1 < FL) bus.mdio_in = v.rin[4'(FL - 2 - i)];
         if (v.mid == 1 && i == 5) bus.write_reg_data = 16'h0000;
         if (v.mid == 2 && i == 10) begin
            bus.r_w            = 1'b0;
            bus.write_reg_data = 16'hFFFF;
            bus.start_flag     = 1'b1;
            @(negedge sys_clk);
            bus.start_flag     = 1'b0;
         end
      end
      wait_level(1'b0);
      ee = v.rw ? ~64'h3FFFF : {64{1'b1}};
      eo = {32'hFFFF_FFFF, 2'b01, (v.rw ? 2'b10 : 2'b01), v.phy, v.rg,
            (v.rw ? 2'b11 : 2'b10), (v.rw ? 16'hFFFF : v.wd)};
      check("bits", idx, go & ee & FMASK, eo & ee & FMASK);
      check("en", idx, ge & FMASK, ee & FMASK);
      check("end_en", idx, {63'b0, bus.mdio_en}, 64'd0);
      check("end_o", idx, {63'b0, bus.mdio_o}, 64'd1);
      if (v.rw) last_rd = v.rin;
      check("rd", idx, {48'b0, bus.read_reg_data}, {48'b0, last_rd});
      k = 0;
      for (int c = 0; c < 3 * LIM; c++) begin
         @(negedge sys_clk);
         if (bus.mdio_en) k++;
      end
      check("idle", idx, 64'(k), 64'd0);
      bus.mdio_in = 1'b0;
   endtask

   initial begin
      vec_t wv;
      bus.start_flag     = 1'b0;
      bus.r_w            = 1'b0;
      bus.phy_add        = '0;
      bus.reg_add        = '0;
      bus.write_reg_data = '0;
      bus.mdio_in        = 1'b0;

      vecs[0] = '{rw: 1'b0, phy: 5'd0,  rg: 5'd0,  wd: 16'h2100, rin: 16'h0000, mid: 0};
      vecs[1] = '{rw: 1'b1, phy: 5'd1,  rg: 5'd2,  wd: 16'h0000, rin: 16'h1234, mid: 0};
      vecs[2] = '{rw: 1'b0, phy: 5'd0,  rg: 5'd0,  wd: 16'h2100, rin: 16'h0000, mid: 1};
      vecs[3] = '{rw: 1'b1, phy: 5'd3,  rg: 5'd4,  wd: 16'h0000, rin: 16'hABCD, mid: 2};
      vecs[4] = '{rw: 1'b0, phy: 5'h1F, rg: 5'h1F, wd: 16'h8001, rin: 16'h0000, mid: 0};
      for (int j = 5; j < 11; j++) begin
         vecs[j].rw  = 1'($urandom_range(0, 1));
         vecs[j].phy = 5'($urandom);
         vecs[j].rg  = 5'($urandom);
         vecs[j].wd  = 16'($urandom);
         vecs[j].rin = 16'($urandom);
         vecs[j].mid = 0;
      end

      repeat (3) @(negedge sys_clk);
      check("rst_mdc", 0, {63'b0, bus.mdc}, 64'd0);
      check("rst_o", 0, {63'b0, bus.mdio_o}, 64'd1);
      check("rst_en", 0, {63'b0, bus.mdio_en}, 64'd0);
      check("rst_rd", 0, {48'b0, bus.read_reg_data}, 64'd0);
      sys_rst = 1'b0;

      for (int j = 0; j < 11; j++) run_frame(vecs[j], j);

      // Reset during the PHYAD field of a read
      drive_req(1'b1, 5'd1, 5'd2, 16'h0000);
      wait_frame_start(100);
      for (int i = 0; i < FL - 26; i++) begin
         wait_level(1'b0);
         wait_level(1'b1);
      end
      @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      check("mrst_mdc", 0, {63'b0, bus.mdc}, 64'd0);
      check("mrst_en", 0, {63'b0, bus.mdio_en}, 64'd0);
      check("mrst_o", 0, {63'b0, bus.mdio_o}, 64'd1);
      check("mrst_rd", 0, {48'b0, bus.read_reg_data}, 64'd0);
      last_rd = '0;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      wv = '{rw: 1'b0, phy: 5'h0A, rg: 5'h15, wd: 16'hA5C3, rin: 16'h0000, mid: 0};
      run_frame(wv, 101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
